tl_grant_responder: RTL and testbench

// Manager-side endpoint for the uncached acquire channel. Consumes acquire messages (header + payload)

---
 rtl/tl_grant_responder.sv | 184 ++++++++++++++++++
 tb/tb_tl_grant_responder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_grant_responder.sv
// Manager-side uncached acquire endpoint: services get/put (single and block) against a
// beat-wide memory port and answers each acquire with a header-swapped grant.
module tl_grant_responder #(
  parameter int HDR_W  = 2,
  parameter int BLK_W  = 26,
  parameter int DATA_W = 64,
  parameter int BEATS  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       acq_valid,
  output logic                       acq_ready,
  input  logic [HDR_W-1:0]           acq_src,
  input  logic [HDR_W-1:0]           acq_dst,
  input  logic [BLK_W-1:0]           acq_addr_block,
  input  logic                       acq_client_xact_id,
  input  logic [$clog2(BEATS)-1:0]   acq_addr_beat,
  input  logic                       acq_is_builtin_type,
  input  logic [2:0]                 acq_a_type,
  input  logic [11:0]                acq_union,
  input  logic [DATA_W-1:0]          acq_data,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic                       mem_req_write,
  output logic [BLK_W+$clog2(BEATS)-1:0] mem_req_addr,
  output logic [DATA_W-1:0]          mem_req_data,
  output logic [7:0]                 mem_req_wmask,
  input  logic                       mem_resp_valid,
  input  logic [DATA_W-1:0]          mem_resp_data,
  output logic                       gnt_valid,
  input  logic                       gnt_ready,
  output logic [HDR_W-1:0]           gnt_src,
  output logic [HDR_W-1:0]           gnt_dst,
  output logic                       gnt_client_xact_id,
  output logic                       gnt_manager_xact_id,
  output logic                       gnt_is_builtin_type,
  output logic [2:0]                 gnt_g_type,
  output logic [$clog2(BEATS)-1:0]   gnt_addr_beat,
  output logic [DATA_W-1:0]          gnt_data
);

  localparam int BEAT_W = $clog2(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  localparam logic [2:0] A_GET       = 3'd0;
  localparam logic [2:0] A_GET_BLOCK = 3'd1;
  localparam logic [2:0] A_PUT       = 3'd2;
  localparam logic [2:0] A_PUT_BLOCK = 3'd3;

  localparam logic [2:0] G_ACK       = 3'd0;
  localparam logic [2:0] G_PUT_ACK   = 3'd2;
  localparam logic [2:0] G_GET_BEAT  = 3'd3;
  localparam logic [2:0] G_GET_BLOCK = 3'd4;

  typedef enum logic [2:0] {IDLE, MREQ, MWAIT, GRANT, PUTNEXT} state_t;

  state_t              state, state_nx;
  logic [BEAT_W-1:0]   cnt, cnt_nx;

  logic [HDR_W-1:0]    src_q, dst_q;
  logic                xact_q;
  logic [BLK_W-1:0]    blk_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [2:0]          op_q;
  logic [2:0]          g_type_q;
  logic [DATA_W-1:0]   data_q;
  logic [7:0]          mask_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                supported;
  logic                is_write, is_read, is_get_block, is_put_block;
  logic                in_mreq, in_gnt;
  logic [3:0]          unused_union;

  assign unused_union = {acq_union[11:9], acq_union[0]};
  assign supported    = acq_is_builtin_type && (acq_a_type <= A_PUT_BLOCK);
  assign is_write     = (op_q == A_PUT) || (op_q == A_PUT_BLOCK);
  assign is_read      = (g_type_q == G_GET_BEAT) || (g_type_q == G_GET_BLOCK);
  assign is_get_block = (g_type_q == G_GET_BLOCK);
  assign is_put_block = (g_type_q == G_PUT_ACK) && (op_q == A_PUT_BLOCK);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (acq_valid) begin
          cnt_nx   = '0;
          state_nx = supported ? MREQ : GRANT;
        end
      end
      MREQ: begin
        if (mem_req_ready) state_nx = MWAIT;
      end
      MWAIT: begin
        if (mem_resp_valid) begin
          if (is_put_block && (cnt != LAST_BEAT)) begin
            cnt_nx   = cnt + BEAT_W'(1);
            state_nx = PUTNEXT;
          end else begin
            state_nx = GRANT;
          end
        end
      end
      PUTNEXT: begin
        if (acq_valid) state_nx = MREQ;
      end
      GRANT: begin
        if (gnt_ready) begin
          if (is_get_block && (cnt != LAST_BEAT)) begin
            cnt_nx   = cnt + BEAT_W'(1);
            state_nx = MREQ;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Transaction payload: captured on acquire, per-beat refresh in PUTNEXT, read data in MWAIT
  always_ff @(posedge clk) begin
    if (state == IDLE && acq_valid) begin
      src_q    <= acq_src;
      dst_q    <= acq_dst;
      xact_q   <= acq_client_xact_id;
      blk_q    <= acq_addr_block;
      beat_q   <= acq_addr_beat;
      op_q     <= acq_a_type;
      data_q   <= acq_data;
      mask_q   <= acq_union[8:1];
      if (!supported)
        g_type_q <= G_ACK;
      else if (acq_a_type == A_GET)
        g_type_q <= G_GET_BEAT;
      else if (acq_a_type == A_GET_BLOCK)
        g_type_q <= G_GET_BLOCK;
      else
        g_type_q <= G_PUT_ACK;
    end
    if (state == PUTNEXT && acq_valid) begin
      beat_q <= acq_addr_beat;
      data_q <= acq_data;
      mask_q <= acq_union[8:1];
    end
    if (state == MWAIT && mem_resp_valid && !is_write)
      rdata_q <= mem_resp_data;
  end

  // Outputs are pure state decodes; payload is forced to zero outside the owning state
  assign in_mreq = (state == MREQ);
  assign in_gnt  = (state == GRANT);

  assign acq_ready     = (state == IDLE) || (state == PUTNEXT);
  assign mem_req_valid = in_mreq;
  assign mem_req_write = in_mreq && is_write;
  assign mem_req_addr  = in_mreq ? {blk_q, (is_get_block ? cnt : beat_q)} : '0;
  assign mem_req_data  = (in_mreq && is_write) ? data_q : '0;
  assign mem_req_wmask = (in_mreq && is_write) ? mask_q : '0;

  assign gnt_valid           = in_gnt;
  assign gnt_src             = in_gnt ? dst_q : '0;
  assign gnt_dst             = in_gnt ? src_q : '0;
  assign gnt_client_xact_id  = in_gnt && xact_q;
  assign gnt_manager_xact_id = 1'b0;
  assign gnt_is_builtin_type = 1'b1;
  assign gnt_g_type          = in_gnt ? g_type_q : '0;
  assign gnt_addr_beat       = !in_gnt ? '0 :
                               is_get_block ? cnt :
                               (g_type_q == G_GET_BEAT) ? beat_q : '0;
  assign gnt_data            = (in_gnt && is_read) ? rdata_q : '0;

endmodule

// File: tb/tb_tl_grant_responder.sv
// Directed bench for tl_grant_responder: stimulus pushes expected memory requests and grants
// into queues; independent monitors pop and compare on every handshake.
module tb_tl_grant_responder;
  localparam int HDR_W  = 2;
  localparam int BLK_W  = 26;
  localparam int DATA_W = 64;
  localparam int BEATS  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              acq_valid, acq_ready;
  logic [HDR_W-1:0]  acq_src, acq_dst;
  logic [BLK_W-1:0]  acq_addr_block;
  logic              acq_client_xact_id;
  logic [2:0]        acq_addr_beat;
  logic              acq_is_builtin_type;
  logic [2:0]        acq_a_type;
  logic [11:0]       acq_union;
  logic [DATA_W-1:0] acq_data;
  logic              mem_req_valid, mem_req_ready, mem_req_write;
  logic [BLK_W+2:0]  mem_req_addr;
  logic [DATA_W-1:0] mem_req_data;
  logic [7:0]        mem_req_wmask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;
  logic              gnt_valid, gnt_ready;
  logic [HDR_W-1:0]  gnt_src, gnt_dst;
  logic              gnt_client_xact_id, gnt_manager_xact_id, gnt_is_builtin_type;
  logic [2:0]        gnt_g_type, gnt_addr_beat;
  logic [DATA_W-1:0] gnt_data;

  tl_grant_responder #(.HDR_W(HDR_W), .BLK_W(BLK_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
    .clk(clk), .reset(reset),
    .acq_valid(acq_valid), .acq_ready(acq_ready),
    .acq_src(acq_src), .acq_dst(acq_dst), .acq_addr_block(acq_addr_block),
    .acq_client_xact_id(acq_client_xact_id), .acq_addr_beat(acq_addr_beat),
    .acq_is_builtin_type(acq_is_builtin_type), .acq_a_type(acq_a_type),
    .acq_union(acq_union), .acq_data(acq_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .gnt_valid(gnt_valid), .gnt_ready(gnt_ready),
    .gnt_src(gnt_src), .gnt_dst(gnt_dst),
    .gnt_client_xact_id(gnt_client_xact_id), .gnt_manager_xact_id(gnt_manager_xact_id),
    .gnt_is_builtin_type(gnt_is_builtin_type), .gnt_g_type(gnt_g_type),
    .gnt_addr_beat(gnt_addr_beat), .gnt_data(gnt_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             w;
    logic [BLK_W+2:0] addr;
    logic [63:0]      data;
    logic [7:0]       mask;
  } mreq_t;

  typedef struct packed {
    logic [1:0]  src;
    logic [1:0]  dst;
    logic        xact;
    logic        mgr;
    logic        bi;
    logic [2:0]  g;
    logic [2:0]  beat;
    logic [63:0] data;
  } gnt_t;

  mreq_t mq[$];
  gnt_t  gq[$];
  int    tests = 0;
  int    fails = 0;
  int    mreq_cnt = 0;
  int    viol = 0;
  bit    toggle_gnt = 0;
  bit    stall_mem = 0;
  bit    hold_beat3 = 0;

  function automatic logic [63:0] rd_model(input logic [BLK_W+2:0] a);
    if (a == 29'h91D) return 64'hDEAD;
    if (a[BLK_W+2:3] == 26'h10) return 64'(a[2:0]) * 64'h11;
    return 64'hC0DE_0000 | 64'(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: compare every memory request and grant handshake against the queues
  initial forever begin
    mreq_t am, em;
    gnt_t  ag, eg;
    @(negedge clk);
    if (!reset) begin
      if ((mem_req_valid || gnt_valid) && acq_ready) viol++;
      if (mem_req_valid && mem_req_ready) begin
        am = '{mem_req_write, mem_req_addr, mem_req_data, mem_req_wmask};
        mreq_cnt++;
        tests++;
        if (mq.size() == 0) begin
          fails++;
          $display("FAIL mem_req unexpected: got %h", am);
        end else begin
          em = mq.pop_front();
          if (am !== em) begin
            fails++;
            $display("FAIL mem_req: got %h expected %h", am, em);
          end
        end
      end
      if (gnt_valid && gnt_ready) begin
        ag = '{gnt_src, gnt_dst, gnt_client_xact_id, gnt_manager_xact_id,
               gnt_is_builtin_type, gnt_g_type, gnt_addr_beat, gnt_data};
        tests++;
        if (gq.size() == 0) begin
          fails++;
          $display("FAIL grant unexpected: got %h", ag);
        end else begin
          eg = gq.pop_front();
          if (ag !== eg) begin
            fails++;
            $display("FAIL grant: got %h expected %h", ag, eg);
          end
        end
      end
    end
  end

  // Memory responder and ready generators
  initial begin
    bit                pend;
    logic [BLK_W+2:0]  addr;
    int                waitc;
    mem_resp_valid = 0;
    mem_resp_data  = '0;
    mem_req_ready  = 1;
    gnt_ready      = 1;
    waitc          = 0;
    forever begin
      @(negedge clk);
      pend = mem_req_valid && mem_req_ready && !reset;
      addr = mem_req_addr;
      @(posedge clk);
      #1;
      if (pend && hold_beat3 && addr == {26'h20, 3'd3}) pend = 0;
      mem_resp_valid = pend;
      mem_resp_data  = pend ? rd_model(addr) : '0;
      gnt_ready      = toggle_gnt ? ~gnt_ready : 1'b1;
      if (!stall_mem) begin
        mem_req_ready = 1;
      end else if (mem_req_valid && mem_req_ready) begin
        mem_req_ready = 0;
        waitc = 0;
      end else if (!mem_req_valid) begin
        mem_req_ready = 0;
        waitc = 0;
      end else if (waitc == 3) begin
        mem_req_ready = 1;
      end else begin
        waitc++;
      end
    end
  end

  task automatic send(input logic [1:0] src, input logic [1:0] dst, input logic xact,
                      input logic [BLK_W-1:0] blk, input logic [2:0] beat, input logic bi,
                      input logic [2:0] at, input logic [11:0] un, input logic [63:0] data);
    bit ok;
    @(posedge clk);
    #1;
    acq_src = src; acq_dst = dst; acq_client_xact_id = xact; acq_addr_block = blk;
    acq_addr_beat = beat; acq_is_builtin_type = bi; acq_a_type = at; acq_union = un;
    acq_data = data; acq_valid = 1;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (acq_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL acq_handshake timeout: acq_ready stayed 0, expected 1");
    end
    @(posedge clk);
    #1;
    acq_valid = 0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (mq.size() == 0 && gq.size() == 0) begin ok = 1; break; end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL drain timeout: pending mem %0d grant %0d, expected 0 0", mq.size(), gq.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit ok;
    int base;
    reset = 1; acq_valid = 0; acq_src = '0; acq_dst = '0; acq_addr_block = '0;
    acq_client_xact_id = 0; acq_addr_beat = '0; acq_is_builtin_type = 0;
    acq_a_type = '0; acq_union = '0; acq_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset acq_ready", 64'(acq_ready), 64'd1);
    chk("reset mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("reset gnt_valid", 64'(gnt_valid), 64'd0);
    chk("reset gnt_data", gnt_data, 64'd0);
    chk("reset mem_req_addr", 64'(mem_req_addr), 64'd0);
    chk("reset mem_req_data", mem_req_data, 64'd0);
    @(posedge clk);
    #1;
    reset = 0;

    // single get
    mq.push_back('{1'b0, 29'h91D, 64'h0, 8'h00});
    gq.push_back('{2'd2, 2'd1, 1'b1, 1'b0, 1'b1, 3'd3, 3'd5, 64'hDEAD});
    send(2'd1, 2'd2, 1'b1, 26'h123, 3'd5, 1'b1, 3'd0, 12'h0, 64'h0);
    wait_done();

    // getBlock with a stuttering grant consumer
    toggle_gnt = 1;
    for (int i = 0; i < 8; i++) begin
      mq.push_back('{1'b0, 29'(26'h10 * 8 + i), 64'h0, 8'h00});
      gq.push_back('{2'd3, 2'd0, 1'b0, 1'b0, 1'b1, 3'd4, 3'(i), 64'(i) * 64'h11});
    end
    send(2'd0, 2'd3, 1'b0, 26'h10, 3'd0, 1'b1, 3'd1, 12'h0, 64'h0);
    wait_done();
    toggle_gnt = 0;

    // putBlock with a slow memory
    stall_mem = 1;
    for (int i = 0; i < 8; i++)
      mq.push_back('{1'b1, 29'(26'h40 * 8 + i), 64'(i + 1), 8'hFF});
    gq.push_back('{2'd1, 2'd2, 1'b0, 1'b0, 1'b1, 3'd2, 3'd0, 64'h0});
    for (int i = 0; i < 8; i++)
      send(2'd2, 2'd1, 1'b0, 26'h40, 3'(i), 1'b1, 3'd3, 12'h1FE, 64'(i + 1));
    wait_done();
    stall_mem = 0;

    // partial-mask put
    mq.push_back('{1'b1, 29'h3E, 64'h1234, 8'h0F});
    gq.push_back('{2'd0, 2'd1, 1'b1, 1'b0, 1'b1, 3'd2, 3'd0, 64'h0});
    send(2'd1, 2'd0, 1'b1, 26'h7, 3'd6, 1'b1, 3'd2, 12'h01E, 64'h1234);
    wait_done();

    // unsupported: non-builtin, then builtin with a_type 5
    gq.push_back('{2'd2, 2'd3, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 64'h0});
    send(2'd3, 2'd2, 1'b0, 26'h5, 3'd1, 1'b0, 3'd1, 12'h0, 64'h0);
    wait_done();
    gq.push_back('{2'd1, 2'd0, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 64'h0});
    send(2'd0, 2'd1, 1'b1, 26'h6, 3'd2, 1'b1, 3'd5, 12'h0, 64'h0);
    wait_done();

    // reset while getBlock beat 3 waits on memory
    hold_beat3 = 1;
    base = mreq_cnt;
    for (int i = 0; i < 4; i++)
      mq.push_back('{1'b0, 29'(26'h20 * 8 + i), 64'h0, 8'h00});
    for (int i = 0; i < 3; i++)
      gq.push_back('{2'd1, 2'd2, 1'b0, 1'b0, 1'b1, 3'd4, 3'(i),
                     64'hC0DE_0000 | 64'(26'h20 * 8 + i)});
    send(2'd2, 2'd1, 1'b0, 26'h20, 3'd0, 1'b1, 3'd1, 12'h0, 64'h0);
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (mreq_cnt == base + 4) begin ok = 1; break; end
    end
    chk("beat3 request reached", 64'(ok), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk);
    #1;
    chk("midreset gnt_valid", 64'(gnt_valid), 64'd0);
    chk("midreset mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("midreset acq_ready", 64'(acq_ready), 64'd1);
    chk("midreset pending grants", 64'(gq.size()), 64'd0);
    reset = 0;
    hold_beat3 = 0;

    // normal get after the abort
    mq.push_back('{1'b0, 29'h2AA, 64'h0, 8'h00});
    gq.push_back('{2'd1, 2'd2, 1'b0, 1'b0, 1'b1, 3'd3, 3'd2, 64'hC0DE_02AA});
    send(2'd2, 2'd1, 1'b0, 26'h55, 3'd2, 1'b1, 3'd0, 12'h0, 64'h0);
    wait_done();

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("leftover mem requests", 64'(mq.size()), 64'd0);
    chk("leftover grants", 64'(gq.size()), 64'd0);
    chk("acq_ready while busy", 64'(viol), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: simulation still running, expected finish");
    $fatal(1, "timeout");
  end
endmodule
